bias_sram_bank: RTL and testbench
=================================

# bias_sram_bank

Multi-bank bias buffer for the CNN accelerator. It is the parametrised successor of the single 2 kB bias SRAM wrapper. `BANK_NUM` instances of the 32b×384w macro sit behind one `sp_ram_intf.memory` host port. A streaming read engine fetches a contiguous run of bias words and hands them to the PE array through a valid/ready interface with a 2-entry skid FIFO. The host port loads biases from the DMA/CPU side; the stream port feeds the accumulators during a layer.

## Interface
- `DATA_W`, 32, word width; must equal the macro width.
- `WORDS_PER_BANK`, 384, valid words per macro.
- `BANK_NUM`, 4, number of macros; must be ≥1.
- `LOCAL_AW`, `$clog2(WORDS_PER_BANK)`, derived; per-bank index width (9).
- `ADDR_W`, `LOCAL_AW+$clog2(BANK_NUM)`, derived; global address width (11).
- `clk` in 1: the single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `mem` sp_ram_intf.memory: host port.
  - `cs`, `oe`, `W_req` (low = write, same polarity as macro WEB), `addr`, `W_data`, `R_data`.
- `str_start` in 1: 1-cycle pulse that starts a stream.
- `str_base` in ADDR_W: first global address.
- `str_len` in ADDR_W+1: number of words to stream.
- `str_busy` out 1: high while the stream is active.
- `str_done` out 1: 1-cycle pulse after the last word is handed off.
- `bias_valid` out 1, `bias_ready` in 1, `bias_data` out DATA_W: stream output handshake.
- `addr_err` out 1: sticky out-of-range flag (see Configuration).

## Operation
- **Address map**
  - Bank = `addr[ADDR_W-1:LOCAL_AW]`; local index = `addr[LOCAL_AW-1:0]`.
  - Local indices ≥ `WORDS_PER_BANK` are holes.
- **Host port**
  - `cs=1` selects exactly one macro by bank; the others get CS=0.
  - `R_data` is muxed from the bank registered at the access cycle.
- **Arbitration**
  - The host has absolute priority.
  - In any cycle with `mem.cs=1`, the stream issues no read; it stalls and does not drop.
- **FSM states**
  - IDLE: `str_start` moves to RUN and latches base/len.
    - `str_len=0`: go directly to DONE instead; no reads are issued.
  - RUN: issue one read per cycle while all of the following hold:
    - remaining>0;
    - host idle;
    - `fifo_cnt + inflight - pop < 2`.
  - RUN moves to DRAIN when remaining reaches 0.
  - DRAIN: wait until inflight=0 and the FIFO is empty, then go to DONE.
  - DONE: pulse `str_done` for one cycle, then go to IDLE.
- `str_start` is ignored when the FSM is not in IDLE.
- **Address increment**
  - Local index goes +1.
  - Local index `WORDS_PER_BANK-1` wraps to 0 of the next bank.
  - The last word of the last bank wraps to address 0.
- **FIFO**
  - 2 entries.
  - Push occurs on macro data return; pop occurs on `bias_valid & bias_ready`.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
- `bias_data` holds its value while `bias_valid=1` and `bias_ready=0`.
- Reset mid-stream: the FSM returns to IDLE, the FIFO and inflight counter are cleared, and the in-flight macro read is discarded.

## Timing
- **Reset values:**
  - `str_busy=0`, `str_done=0`, `bias_valid=0`, `bias_data=0`, `addr_err=0`.
  - `mem.R_data` shows the unregistered macro DO through a mux whose select resets to bank 0.
- **Host read latency:** address at cycle N, `R_data` valid in cycle N+1.
- **Host write:** data is committed at the edge ending cycle N.
- **Stream latency:** `str_start` sampled in cycle 0 gives first read in cycle 1 and `bias_valid`=1 in cycle 3.
- **Throughput:** with `bias_ready` held high and no host traffic, one word per cycle.
- **Completion:** `str_done` pulses 1 cycle after the final handshake.
- `str_busy` is high from cycle 1 through the `str_done` cycle, inclusive.

## Configuration
- Macro: `BIAS_SRAM_ADDR_CHK_EN`.
- **Defined:**
  - A host or stream access to a hole or to bank ≥ `BANK_NUM` sets `addr_err`.
  - `addr_err` clears only on reset.
  - The access is suppressed: all CS=0, and the read returns 0.
  - For a stream, the suppressed access still counts as a word.
- **Undefined:**
  - `addr_err` is tied to 0.
  - Out-of-range local indices reach the macro unchecked; the result is undefined.

## Test plan
- Host writes `0xA5A50000+i` to global addr 0..3 in each bank, then reads them back. Each `R_data` matches one cycle after its address.
- Stream with base=382 (bank 0), len=4, ready=1. Outputs are the words at global 382, 383, 512, 513 on 4 consecutive cycles, then `str_done`.
- Stream len=8 with `bias_ready` toggled 1,0,0,1,…
  - No word is lost or duplicated.
  - `bias_data` is stable across stalls.
  - Inflight never exceeds FIFO room.
- Host reads injected on cycles 2 and 3 of a len=6 stream. Host data is correct, and the stream completes with the correct ordered data and 2 cycles of extra latency.
- `str_len=0`: `str_done` pulses at cycle 1, no macro CS is asserted, and `bias_valid` stays 0. Separately, assert `rstn`=0 mid-stream: all outputs return to reset values, and a new stream then runs cleanly.
- With `BIAS_SRAM_ADDR_CHK_EN` defined, a host read at local index 400 sets `addr_err` and returns 0. Without the macro, `addr_err` stays 0.

Source files
------------

// File: rtl/bias_sram_bank_if.sv
// Host-side single-port RAM interface: chip select, output enable,
// active-low write request, address, write data and read data.
interface sp_ram_intf #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              cs;
    logic              oe;
    logic              W_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] W_data;
    logic [DATA_W-1:0] R_data;

    modport memory (input cs, oe, W_req, addr, W_data, output R_data);
    modport host   (output cs, oe, W_req, addr, W_data, input R_data);
endinterface

// File: rtl/bias_sram_bank.sv
// Multi-bank bias buffer: BANK_NUM 32b x 384w macros behind one host port plus a
// streaming read engine with a 2-entry skid FIFO. Define BIAS_SRAM_ADDR_CHK_EN for range checking.

module bias_sram_macro #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 384,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              cs,
    input  logic              web,
    input  logic [AW-1:0]     a,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] dout_q;

    // NOTE: storage and its output latch have no reset; an SRAM macro cannot clear its array.
    always_ff @(posedge clk) begin
        if (cs) begin
            if (!web) mem_q[a] <= di;
            else      dout_q   <= mem_q[a];
        end
    end

    assign dout = dout_q;
endmodule

module bias_sram_bank #(
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_BANK = 384,
    parameter int BANK_NUM       = 4,
    parameter int LOCAL_AW       = $clog2(WORDS_PER_BANK),
    parameter int ADDR_W         = LOCAL_AW + $clog2(BANK_NUM)
) (
    input  logic              clk,
    input  logic              rstn,
    sp_ram_intf.memory        mem,
    input  logic              str_start,
    input  logic [ADDR_W-1:0] str_base,
    input  logic [ADDR_W:0]   str_len,
    output logic              str_busy,
    output logic              str_done,
    output logic              bias_valid,
    input  logic              bias_ready,
    output logic [DATA_W-1:0] bias_data,
    output logic              addr_err
);
    localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam logic [ADDR_W:0] LEN_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     rem_q;
    logic                busy_q, done_q;
    logic                inflight_q;
    logic [BANK_W-1:0]   rd_bank_q;
    logic                rd_zero_q;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]   slot0_q, slot0_d, slot1_q, slot1_d;

    logic                host_rd, host_wr, issue, push, pop;
    logic                acc_rd, acc_wr, acc_bad;
    logic [ADDR_W-1:0]   acc_addr;
    logic [BANK_W-1:0]   acc_bank;
    logic [BANK_NUM-1:0] macro_cs;
    logic [DATA_W-1:0]   macro_dout [BANK_NUM];
    logic [DATA_W-1:0]   rd_data;

    // Walk valid words only: the last index of a bank jumps to the next bank, the last bank to 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (int'(a[LOCAL_AW-1:0]) != WORDS_PER_BANK - 1) return a + ADDR_W'(1);
        if (int'(a >> LOCAL_AW) >= BANK_NUM - 1) return '0;
        return ADDR_W'((int'(a >> LOCAL_AW) + 1) << LOCAL_AW);
    endfunction

    assign host_rd  = mem.cs && mem.oe && mem.W_req;
    assign host_wr  = mem.cs && !mem.W_req;
    assign pop      = bias_valid && bias_ready;
    assign push     = inflight_q;

    // The host owns the macros whenever cs is high; the stream only reads while FIFO room remains.
    assign issue    = (state_q == S_RUN) && (rem_q != '0) && !mem.cs &&
                      (({1'b0, fifo_cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

    assign acc_addr = mem.cs ? mem.addr : addr_q;
    assign acc_rd   = host_rd || issue;
    assign acc_wr   = host_wr;
    assign acc_bank = BANK_W'(acc_addr >> LOCAL_AW);

`ifdef BIAS_SRAM_ADDR_CHK_EN
    logic addr_err_q;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (int'(a[LOCAL_AW-1:0]) >= WORDS_PER_BANK) || (int'(a >> LOCAL_AW) >= BANK_NUM);
    endfunction

    assign acc_bad = (acc_rd || acc_wr) && out_of_range(acc_addr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) addr_err_q <= 1'b0;
        else       addr_err_q <= addr_err_q || acc_bad;
    end

    assign addr_err = addr_err_q;
`else
    assign acc_bad  = 1'b0;
    assign addr_err = 1'b0;
`endif

    always_comb begin
        macro_cs = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            macro_cs[b] = (acc_rd || acc_wr) && !acc_bad && (acc_bank == BANK_W'(b));
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        bias_sram_macro #(
            .DATA_W (DATA_W),
            .WORDS  (WORDS_PER_BANK),
            .AW     (LOCAL_AW)
        ) u_macro (
            .clk  (clk),
            .cs   (macro_cs[b]),
            .web  (!acc_wr),
            .a    (acc_addr[LOCAL_AW-1:0]),
            .di   (mem.W_data),
            .dout (macro_dout[b])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
            rd_bank_q  <= '0;
            rd_zero_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (acc_rd) begin
                rd_bank_q <= acc_bank;
                rd_zero_q <= acc_bad;
            end
        end
    end

    assign rd_data    = rd_zero_q ? '0 : macro_dout[rd_bank_q];
    assign mem.R_data = rd_data;

    // NOTE: combinational next-state uses blocking '=' with every output defaulted first, so no latch is inferred.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) slot0_d = rd_data;
                else                    slot1_d = rd_data;
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                if (fifo_cnt_q == 2'd2) slot0_d = slot1_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd2) begin
                    slot0_d = slot1_q;
                    slot1_d = rd_data;
                end else begin
                    slot0_d = rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_cnt_q <= 2'd0;
            slot0_q    <= '0;
            slot1_q    <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
        end
    end

    assign bias_valid = (fifo_cnt_q != 2'd0);
    assign bias_data  = slot0_q;

    // DRAIN looks at the FIFO's next count so str_done lands one cycle after the final handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (str_start) begin
                        addr_q <= str_base;
                        rem_q  <= str_len;
                        busy_q <= 1'b1;
                        if (str_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr_q <= next_addr(addr_q);
                        rem_q  <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!inflight_q && (fifo_cnt_d == 2'd0)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign str_busy = busy_q;
    assign str_done = done_q;
endmodule

// File: tb/tb_bias_sram_bank.sv
// Scoreboard bench for bias_sram_bank: host and stream expectations come from a
// linear-word reference memory; a negedge monitor pops and compares.
module tb_bias_sram_bank;
    localparam int ADDR_W = 11;
    localparam int WPB    = 384;
    localparam int NB     = 4;
    localparam int LAW    = 9;
    localparam int TOTAL  = WPB * NB;
    localparam int LIMIT  = 400;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sp_ram_intf #(.ADDR_W(ADDR_W), .DATA_W(32)) mem_if ();

    logic              str_start = 1'b0;
    logic [ADDR_W-1:0] str_base = '0;
    logic [ADDR_W:0]   str_len = '0;
    logic              str_busy, str_done, bias_valid, addr_err;
    logic              bias_ready = 1'b1;
    logic [31:0]       bias_data;

    bias_sram_bank #(.DATA_W(32), .WORDS_PER_BANK(WPB), .BANK_NUM(NB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mem        (mem_if),
        .str_start  (str_start),
        .str_base   (str_base),
        .str_len    (str_len),
        .str_busy   (str_busy),
        .str_done   (str_done),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .bias_data  (bias_data),
        .addr_err   (addr_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not as expected", name);
    endtask

    typedef struct {
        logic [31:0] d;
        bit          chk;
    } host_exp_t;

    logic [31:0] ref_mem [int];
    host_exp_t   host_q [$];
    logic [31:0] exp_q [$];
    int          cyc = 0;

    always @(posedge clk) cyc++;

    // Word n of the flat valid-word space lives at bank n/384, index n%384.
    function automatic logic [ADDR_W-1:0] addr_of(input int n);
        return ADDR_W'(((n / WPB) << LAW) | (n % WPB));
    endfunction

    task automatic set_host_off();
        mem_if.cs = 1'b0; mem_if.oe = 1'b0; mem_if.W_req = 1'b1;
        mem_if.addr = '0; mem_if.W_data = '0;
    endtask

    task automatic set_host_read(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit chk);
        mem_if.cs = 1'b1; mem_if.oe = 1'b1; mem_if.W_req = 1'b1; mem_if.addr = a;
        host_q.push_back(host_exp_t'{d, chk});
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        mem_if.cs = 1'b1; mem_if.oe = 1'b0; mem_if.W_req = 1'b0;
        mem_if.addr = a; mem_if.W_data = d;
        ref_mem[int'(a)] = d;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit chk);
        @(posedge clk); #1;
        set_host_read(a, d, chk);
    endtask

    task automatic host_idle();
        @(posedge clk); #1;
        set_host_off();
    endtask

    // Monitor: host read data one cycle after the address, stream words in order, stall stability.
    bit          rd_prev = 0, prev_stall = 0, expect_hs = 0, any_cs = 0;
    logic [31:0] prev_data = '0;
    int          last_hs = -10;
    host_exp_t   mon_h;

    always @(negedge clk) begin
        if (!rstn) begin
            rd_prev    = 0;
            prev_stall = 0;
        end else begin
            if (rd_prev) begin
                if (host_q.size() == 0) fail("host_extra_read");
                else begin
                    mon_h = host_q.pop_front();
                    if (mon_h.chk) check("host_rdata", mem_if.R_data, mon_h.d);
                end
            end
            rd_prev = mem_if.cs && mem_if.oe && mem_if.W_req;
            if (prev_stall) begin
                check("stall_valid", bias_valid, 1);
                check("stall_data", bias_data, prev_data);
            end
            if (bias_valid && bias_ready) begin
                if (exp_q.size() == 0) fail("stream_extra_word");
                else check("stream_data", bias_data, exp_q.pop_front());
                last_hs = cyc;
            end
            prev_stall = bias_valid && !bias_ready;
            prev_data  = bias_data;
            if (|dut.macro_cs) any_cs = 1;
            if (str_busy) check("fifo_room", (int'(dut.fifo_cnt_q) + int'(dut.inflight_q)) <= 2, 1);
            if (str_done && expect_hs) check("done_after_last_hs", cyc - last_hs, 1);
        end
    end

    // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random. hmode: 0 none, 1 reads at cycles 2-3, 2 random.
    task automatic run_stream(input int n0, input int len, input int rmode, input int hmode,
                              output int first_rel, output int done_rel);
        int pat[4] = '{1, 0, 0, 1};
        int n = n0;
        int m;
        bit seen_done = 0;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(ref_mem[int'(addr_of(n))]);
            n = (n + 1) % TOTAL;
        end
        expect_hs = (len > 0);
        any_cs    = 0;
        first_rel = -1;
        done_rel  = -1;
        @(posedge clk); #1;
        str_start = 1'b1; str_base = addr_of(n0); str_len = (ADDR_W+1)'(len);
        set_host_off();
        bias_ready = 1'b1;
        #3 check("busy_at_start", str_busy, 0);
        for (int rel = 1; rel <= LIMIT && !seen_done; rel++) begin
            @(posedge clk); #1;
            str_start = 1'b0;
            bias_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[rel % 4][0] : 1'($urandom_range(0, 1));
            if ((hmode == 1 && (rel == 2 || rel == 3)) || (hmode == 2 && $urandom_range(0, 3) == 0)) begin
                m = $urandom_range(0, TOTAL - 1);
                set_host_read(addr_of(m), ref_mem[int'(addr_of(m))], 1);
            end else begin
                set_host_off();
            end
            #3;
            if (first_rel < 0 && bias_valid) first_rel = rel;
            check("busy_in_stream", str_busy, 1);
            if (str_done) begin
                seen_done = 1;
                done_rel  = rel;
            end
        end
        if (!seen_done) fail("stream_timeout");
        @(posedge clk); #1;
        set_host_off();
        bias_ready = 1'b1;
        #3;
        check("busy_after_done", str_busy, 0);
        check("done_one_cycle", str_done, 0);
        check("stream_words_left", exp_q.size(), 0);
        expect_hs = 0;
    endtask

    int fr, dr, n0;

    initial begin
        set_host_off();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", str_busy, 0);
        check("rst_done", str_done, 0);
        check("rst_valid", bias_valid, 0);
        check("rst_data", bias_data, 0);
        check("rst_addr_err", addr_err, 0);
        rstn = 1'b1;

        for (int n = 0; n < TOTAL; n++) host_write(addr_of(n), $urandom);
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 4; i++)
                host_write(ADDR_W'((b << LAW) | i), 32'hA5A5_0000 + 32'(b * 4 + i));
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 4; i++)
                host_read(ADDR_W'((b << LAW) | i), 32'hA5A5_0000 + 32'(b * 4 + i), 1);
        host_idle();
        host_idle();

        run_stream(382, 4, 0, 0, fr, dr);
        check("bank_cross_first_valid", fr, 3);
        check("bank_cross_done", dr, 7);

        run_stream(TOTAL - 2, 4, 0, 0, fr, dr);
        check("wrap_done", dr, 7);

        run_stream(1000, 8, 1, 0, fr, dr);

        run_stream(50, 6, 0, 1, fr, dr);
        check("host_stall_first_valid", fr, 3);
        check("host_stall_done", dr, 11);

        run_stream(200, 0, 0, 0, fr, dr);
        check("len0_done", dr, 1);
        check("len0_no_cs", any_cs, 0);
        check("len0_no_valid", fr < 0, 1);

        for (int k = 0; k < 20; k++) exp_q.push_back(ref_mem[int'(addr_of(100 + k))]);
        @(posedge clk); #1;
        str_start = 1'b1; str_base = addr_of(100); str_len = 12'd20;
        repeat (5) begin
            @(posedge clk); #1;
            str_start = 1'b0;
        end
        rstn = 1'b0;
        #2;
        check("midrst_busy", str_busy, 0);
        check("midrst_done", str_done, 0);
        check("midrst_valid", bias_valid, 0);
        check("midrst_data", bias_data, 0);
        check("midrst_addr_err", addr_err, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        run_stream(700, 5, 0, 0, fr, dr);
        check("after_rst_first_valid", fr, 3);
        check("after_rst_done", dr, 8);

        for (int t = 0; t < 12; t++) begin
            n0 = (t % 3 == 0) ? TOTAL - 1 - $urandom_range(0, 20) : $urandom_range(0, TOTAL - 1);
            run_stream(n0, $urandom_range(1, 40), 2, 2, fr, dr);
        end

`ifdef BIAS_SRAM_ADDR_CHK_EN
        host_read(ADDR_W'(400), 32'h0, 1);
        host_idle();
        #3 check("hole_sets_addr_err", addr_err, 1);
        host_read(addr_of(5), ref_mem[int'(addr_of(5))], 1);
        host_idle();
        #3 check("addr_err_sticky", addr_err, 1);
        rstn = 1'b0;
        #2 check("addr_err_cleared", addr_err, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
`else
        host_read(ADDR_W'(400), 32'h0, 0);
        host_idle();
        #3 check("no_chk_addr_err", addr_err, 0);
`endif

        repeat (3) host_idle();
        check("host_reads_left", host_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
